// File: rtl/rv32i_instruction_decoder.sv
// rv32i_instruction_decoder
// Registered RV32I decode stage. One instruction is accepted every clock.
// Its decoded fields appear on the outputs one clock later. Illegal or
// unsupported encodings decode to a NOP, which only advances the PC.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (all outputs 0)
//   instruction       fetched instruction word
//   rs1/rs2/rd_addr   register addresses (0 when the format does not use them)
//   rfile_we          register-file write (forced 0 when rd = x0)
//   pc_we             PC load for jumps and branches
//   pc_increment      PC advances by 4 (never set together with pc_we)
//   memory_we/re      data-memory store / load
//   low_imm           I/S/B immediate (the B form holds imm[12:1])
//   upper_imm         U immediate, or the J immediate imm[20:1]
//   alu_op_group, op  operation group and the operation within that group
//   fence_sig/mode    FENCE pred/succ bits and fm field
module rv32i_instruction_decoder #(
    parameter int IALIGN     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 12,
    parameter int OP_GROUP_W = 4,
    parameter int OP_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IALIGN-1:0]        instruction,
    output logic [REG_ADDR_W-1:0]    rs1_addr,
    output logic [REG_ADDR_W-1:0]    rs2_addr,
    output logic [REG_ADDR_W-1:0]    rd_addr,
    output logic                     rfile_we,
    output logic                     pc_we,
    output logic                     pc_increment,
    output logic                     memory_we,
    output logic                     memory_re,
    output logic [IMM_W-1:0]         low_imm,
    output logic [IALIGN-IMM_W-1:0]  upper_imm,
    output logic [OP_GROUP_W-1:0]    alu_op_group,
    output logic [OP_W-1:0]          op,
    output logic [7:0]               fence_sig,
    output logic [3:0]               fence_mode
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [OP_GROUP_W-1:0] GRP_NOP    = 4'd0;
    localparam logic [OP_GROUP_W-1:0] GRP_OP_IMM = 4'd1;
    localparam logic [OP_GROUP_W-1:0] GRP_OP     = 4'd2;
    localparam logic [OP_GROUP_W-1:0] GRP_LUI    = 4'd3;
    localparam logic [OP_GROUP_W-1:0] GRP_AUIPC  = 4'd4;
    localparam logic [OP_GROUP_W-1:0] GRP_JAL    = 4'd5;
    localparam logic [OP_GROUP_W-1:0] GRP_JALR   = 4'd6;
    localparam logic [OP_GROUP_W-1:0] GRP_BRANCH = 4'd7;
    localparam logic [OP_GROUP_W-1:0] GRP_LOAD   = 4'd8;
    localparam logic [OP_GROUP_W-1:0] GRP_STORE  = 4'd9;
    localparam logic [OP_GROUP_W-1:0] GRP_FENCE  = 4'd10;
    localparam logic [OP_GROUP_W-1:0] GRP_SYSTEM = 4'd11;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    logic [REG_ADDR_W-1:0]   n_rs1, n_rs2, n_rd;
    logic                    n_rf_we, n_pc_we, n_pc_inc, n_mem_we, n_mem_re;
    logic [IMM_W-1:0]        n_limm;
    logic [IALIGN-IMM_W-1:0] n_uimm;
    logic [OP_GROUP_W-1:0]   n_grp;
    logic [OP_W-1:0]         n_op;
    logic [7:0]              n_fsig;
    logic [3:0]              n_fmode;

    always_comb begin
        // Every path starts from the NOP decode: only the PC advances.
        n_rs1    = '0;
        n_rs2    = '0;
        n_rd     = '0;
        n_rf_we  = 1'b0;
        n_pc_we  = 1'b0;
        n_pc_inc = 1'b1;
        n_mem_we = 1'b0;
        n_mem_re = 1'b0;
        n_limm   = '0;
        n_uimm   = '0;
        n_grp    = GRP_NOP;
        n_op     = '0;
        n_fsig   = '0;
        n_fmode  = '0;

        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                n_grp   = (opcode == OPC_LUI) ? GRP_LUI : GRP_AUIPC;
                n_rd    = instruction[11:7];
                n_uimm  = instruction[31:12];
                n_rf_we = 1'b1;
            end
            OPC_JAL: begin
                n_grp    = GRP_JAL;
                n_rd     = instruction[11:7];
                n_uimm   = {instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21]};
                n_rf_we  = 1'b1;
                n_pc_we  = 1'b1;
                n_pc_inc = 1'b0;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    n_grp    = GRP_JALR;
                    n_rs1    = instruction[19:15];
                    n_rd     = instruction[11:7];
                    n_limm   = instruction[31:20];
                    n_rf_we  = 1'b1;
                    n_pc_we  = 1'b1;
                    n_pc_inc = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    n_grp    = GRP_BRANCH;
                    n_op     = {1'b0, funct3};
                    n_rs1    = instruction[19:15];
                    n_rs2    = instruction[24:20];
                    n_limm   = {instruction[31], instruction[7],
                                instruction[30:25], instruction[11:8]};
                    n_pc_we  = 1'b1;
                    n_pc_inc = 1'b0;
                end
            end
            OPC_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    n_grp    = GRP_LOAD;
                    n_op     = {1'b0, funct3};
                    n_rs1    = instruction[19:15];
                    n_rd     = instruction[11:7];
                    n_limm   = instruction[31:20];
                    n_mem_re = 1'b1;
                    n_rf_we  = 1'b1;
                end
            end
            OPC_STORE: begin
                if (!funct3[2] && funct3 != 3'b011) begin
                    n_grp    = GRP_STORE;
                    n_op     = {1'b0, funct3};
                    n_rs1    = instruction[19:15];
                    n_rs2    = instruction[24:20];
                    n_limm   = {instruction[31:25], instruction[11:7]};
                    n_mem_we = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Only the shift encodings constrain the upper immediate bits.
                if ((funct3 == 3'b001 && funct7 == F7_ZERO) ||
                    (funct3 == 3'b101 && (funct7 == F7_ZERO || funct7 == F7_ALT)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    n_grp   = GRP_OP_IMM;
                    n_op    = {(funct3 == 3'b101) && instruction[30], funct3};
                    n_rs1   = instruction[19:15];
                    n_rd    = instruction[11:7];
                    n_limm  = instruction[31:20];
                    n_rf_we = 1'b1;
                end
            end
            OPC_OP: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    n_grp   = GRP_OP;
                    n_op    = {instruction[30], funct3};
                    n_rs1   = instruction[19:15];
                    n_rs2   = instruction[24:20];
                    n_rd    = instruction[11:7];
                    n_rf_we = 1'b1;
                end
            end
            OPC_FENCE: begin
                if (funct3 == 3'b000) begin
                    n_grp   = GRP_FENCE;
                    n_fsig  = instruction[27:20];
                    n_fmode = instruction[31:28];
                end
            end
            OPC_SYSTEM: begin
                // ECALL / EBREAK are the only accepted SYSTEM encodings.
                if (instruction[31:7] == 25'h0 || instruction[31:7] == 25'h2000)
                    n_grp = GRP_SYSTEM;
            end
            default: ;
        endcase

        // Writes to x0 are discarded at decode.
        if (n_rd == '0)
            n_rf_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_addr     <= '0;
            rs2_addr     <= '0;
            rd_addr      <= '0;
            rfile_we     <= 1'b0;
            pc_we        <= 1'b0;
            pc_increment <= 1'b0;
            memory_we    <= 1'b0;
            memory_re    <= 1'b0;
            low_imm      <= '0;
            upper_imm    <= '0;
            alu_op_group <= '0;
            op           <= '0;
            fence_sig    <= '0;
            fence_mode   <= '0;
        end else begin
            rs1_addr     <= n_rs1;
            rs2_addr     <= n_rs2;
            rd_addr      <= n_rd;
            rfile_we     <= n_rf_we;
            pc_we        <= n_pc_we;
            pc_increment <= n_pc_inc;
            memory_we    <= n_mem_we;
            memory_re    <= n_mem_re;
            low_imm      <= n_limm;
            upper_imm    <= n_uimm;
            alu_op_group <= n_grp;
            op           <= n_op;
            fence_sig    <= n_fsig;
            fence_mode   <= n_fmode;
        end
    end

endmodule

// File: tb/tb_rv32i_instruction_decoder.sv
// Directed bench for rv32i_instruction_decoder: hand-encoded instructions with
// hand-computed decode fields, checked one cycle after each is presented.
module tb_rv32i_instruction_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rfile_we, pc_we, pc_increment, memory_we, memory_re;
    logic [11:0] low_imm;
    logic [19:0] upper_imm;
    logic [3:0]  alu_op_group, op;
    logic [7:0]  fence_sig;
    logic [3:0]  fence_mode;

    int checks = 0;
    int errors = 0;

    rv32i_instruction_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .rfile_we     (rfile_we),
        .pc_we        (pc_we),
        .pc_increment (pc_increment),
        .memory_we    (memory_we),
        .memory_re    (memory_re),
        .low_imm      (low_imm),
        .upper_imm    (upper_imm),
        .alu_op_group (alu_op_group),
        .op           (op),
        .fence_sig    (fence_sig),
        .fence_mode   (fence_mode)
    );

    always #5 clk = ~clk;

    // Present one instruction mid-cycle, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] ins);
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    // Field order: rs1 rs2 rd | rf_we pc_we pc_inc mem_we mem_re | limm uimm grp op fsig fmode
    task automatic expect_out(input string tag,
                              input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                              input logic [4:0] e_rd,
                              input logic e_rf, input logic e_pcwe, input logic e_pcinc,
                              input logic e_mwe, input logic e_mre,
                              input logic [11:0] e_limm, input logic [19:0] e_uimm,
                              input logic [3:0] e_grp, input logic [3:0] e_op,
                              input logic [7:0] e_fsig, input logic [3:0] e_fmode);
        logic [71:0] obs, exp;
        obs = {rs1_addr, rs2_addr, rd_addr, rfile_we, pc_we, pc_increment,
               memory_we, memory_re, low_imm, upper_imm, alu_op_group, op,
               fence_sig, fence_mode};
        exp = {e_rs1, e_rs2, e_rd, e_rf, e_pcwe, e_pcinc, e_mwe, e_mre,
               e_limm, e_uimm, e_grp, e_op, e_fsig, e_fmode};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        instruction = 32'h0000_0033;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_out("reset", 0,0,0, 0,0,0,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);

        // First decode after release: ADD x0,x0,x0 keeps group but drops the write.
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        expect_out("add_x0", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd2, 4'd0, 8'h0, 4'h0);

        step(32'hFFFF_FFFF);
        expect_out("all_ones_nop", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);
        step(32'hCAD6_9AB7);
        expect_out("lui", 0,0,5'h15, 1,0,1,0,0, 12'h0, 20'hCAD69, 4'd3, 4'd0, 8'h0, 4'h0);
        step(32'h69CA_D517);
        expect_out("auipc", 0,0,5'h0A, 1,0,1,0,0, 12'h0, 20'h69CAD, 4'd4, 4'd0, 8'h0, 4'h0);
        step(32'h0080_00EF);
        expect_out("jal", 0,0,5'd1, 1,1,0,0,0, 12'h0, 20'h00004, 4'd5, 4'd0, 8'h0, 4'h0);
        step(32'h0051_2423);
        expect_out("sw", 5'd2,5'd5,0, 0,0,1,1,0, 12'h008, 20'h0, 4'd9, 4'd2, 8'h0, 4'h0);
        step(32'hFFC1_A383);
        expect_out("lw", 5'd3,0,5'd7, 1,0,1,0,1, 12'hFFC, 20'h0, 4'd8, 4'd2, 8'h0, 4'h0);
        step(32'h0001_A003);
        expect_out("lw_x0", 5'd3,0,0, 0,0,1,0,1, 12'h000, 20'h0, 4'd8, 4'd2, 8'h0, 4'h0);
        step(32'h0FF0_000F);
        expect_out("fence", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd10, 4'd0, 8'hFF, 4'h0);
        step(32'h8330_000F);
        expect_out("fence_tso", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd10, 4'd0, 8'h33, 4'h8);
        step(32'h0020_8463);
        expect_out("beq", 5'd1,5'd2,0, 0,1,0,0,0, 12'h004, 20'h0, 4'd7, 4'd0, 8'h0, 4'h0);
        step(32'h0020_A463);
        expect_out("branch_f3_010_nop", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);
        step(32'h4033_5293);
        expect_out("srai", 5'd6,0,5'd5, 1,0,1,0,0, 12'h403, 20'h0, 4'd1, 4'hD, 8'h0, 4'h0);
        step(32'h4033_1293);
        expect_out("slli_bad_f7_nop", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);
        step(32'h4020_81B3);
        expect_out("sub", 5'd1,5'd2,5'd3, 1,0,1,0,0, 12'h0, 20'h0, 4'd2, 4'h8, 8'h0, 4'h0);
        step(32'h4020_91B3);
        expect_out("sll_bad_f7_nop", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);
        step(32'h0101_00E7);
        expect_out("jalr", 5'd2,0,5'd1, 1,1,0,0,0, 12'h010, 20'h0, 4'd6, 4'd0, 8'h0, 4'h0);
        step(32'h0000_0073);
        expect_out("ecall", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd11, 4'd0, 8'h0, 4'h0);
        step(32'h0010_0073);
        expect_out("ebreak", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd11, 4'd0, 8'h0, 4'h0);
        step(32'h3000_1073);
        expect_out("csrrw_nop", 0,0,0, 0,0,1,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);

        // Reset mid-stream: the LUI sampled under reset never appears.
        @(negedge clk);
        instruction = 32'hCAD6_9AB7;
        rst = 1'b1;
        @(posedge clk); #1;
        expect_out("mid_reset", 0,0,0, 0,0,0,0,0, 12'h0, 20'h0, 4'd0, 4'd0, 8'h0, 4'h0);
        @(negedge clk); rst = 1'b0;
        step(32'hFFF0_0093);
        expect_out("addi_after_reset", 0,0,5'd1, 1,0,1,0,0, 12'hFFF, 20'h0, 4'd1, 4'd0, 8'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_instruction_decoder.md
Name: rv32i_instruction_decoder

Overview:
- Registered RV32I instruction decoder in the core's decode stage.
- Takes one 32-bit fetched instruction per clock and splits it into register addresses and immediates.
- Produces register-file, PC and memory enables, plus an ALU operation group/opcode for the execute stage.
- Unsupported or illegal encodings decode to a NOP.

Parameters:
- IALIGN, 32, instruction width in bits.
- REG_ADDR_W, 5, register address width.
- IMM_W, 12, low immediate width.
- OP_GROUP_W, 4, ALU operation-group width.
- OP_W, 4, operation-code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instruction  in  32  instruction word to decode.
- rs1_addr  out  5  source register 1.
- rs2_addr  out  5  source register 2.
- rd_addr  out  5  destination register.
- rfile_we  out  1  register-file write enable.
- pc_we  out  1  PC load (jump/branch target).
- pc_increment  out  1  PC advances by 4.
- memory_we  out  1  data-memory store.
- memory_re  out  1  data-memory load.
- low_imm  out  12  I/S/B immediate field.
- upper_imm  out  20  U immediate (bits 31:12) or J immediate.
- alu_op_group  out  4  operation group.
- op  out  4  operation within group.
- fence_sig  out  8  FENCE pred/succ.
- fence_mode  out  4  FENCE fm.

Behaviour:
- Clocking and latency: all outputs registered. `instruction` sampled at each rising edge; decoded values appear one cycle later. No handshake; a new instruction is accepted every cycle.
- Reset: while rst=1 at an edge, every output is 0, including pc_increment. The first decode appears on the edge after rst drops. Asserting rst mid-stream discards the pending decode.
- Default (NOP): applies to any unlisted opcode, funct3/funct7 combination invalid for RV32I, or 0xFFFF_FFFF.
  - pc_increment=1; all other enables 0.
  - Addresses, immediates, fence fields and alu_op_group all 0.
- Unused fields are driven 0 (e.g. rs2_addr for I-type).
- rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
- alu_op_group encoding: 0 NOP, 1 OP_IMM, 2 OP, 3 LUI, 4 AUIPC, 5 JAL, 6 JALR, 7 BRANCH, 8 LOAD, 9 STORE, 10 FENCE, 11 SYSTEM.
- op:
  - OP: {inst[30], funct3}.
  - OP_IMM: {inst[30] only for SRAI (funct3=101), funct3}.
  - BRANCH/LOAD/STORE: {0, funct3}.
  - Other groups: 0.
- Per-opcode decode:
  - LUI 0110111 / AUIPC 0010111: rd; upper_imm = inst[31:12]; rfile_we=1; pc_increment=1.
  - JAL 1101111: rd; upper_imm = {inst[31], inst[19:12], inst[20], inst[30:21]} (imm[20:1]); rfile_we=1; pc_we=1; pc_increment=0.
  - JALR 1100111 (funct3=000): rs1, rd; low_imm = inst[31:20]; rfile_we=1; pc_we=1; pc_increment=0.
  - BRANCH 1100011 (funct3 not 010/011): rs1, rs2; low_imm = {inst[31], inst[7], inst[30:25], inst[11:8]} (imm[12:1]); pc_we=1; pc_increment=0. Execute gates the taken/not-taken decision.
  - LOAD 0000011 (funct3 in 000,001,010,100,101): rs1, rd; low_imm = inst[31:20]; memory_re=1; rfile_we=1; pc_increment=1.
  - STORE 0100011 (funct3 000–010): rs1, rs2; low_imm = {inst[31:25], inst[11:7]}; memory_we=1; pc_increment=1.
  - OP_IMM 0010011: rs1, rd; low_imm = inst[31:20]; rfile_we=1; pc_increment=1. Shifts require inst[31:25] = 0000000, or 0100000 for SRAI.
  - OP 0110011: rs1, rs2, rd; rfile_we=1; pc_increment=1. inst[31:25] must be 0000000, or 0100000 for ADD/SUB and SRL/SRA.
  - FENCE 0001111 (funct3=000): fence_sig = inst[27:20]; fence_mode = inst[31:28]; pc_increment=1.
  - SYSTEM 1110011: ECALL/EBREAK only; group 11, no writes, pc_increment=1.
- rd = x0: rd_addr=0 and rfile_we forced 0.
- pc_we and pc_increment are never both 1.
- memory_we and memory_re are never both 1.

Test Plan:
- rst=1 for 2 cycles with instruction=0x0000_0033 -> all outputs 0. Release rst -> next cycle group=2, rd=0, rfile_we=0.
- instruction=0xFFFF_FFFF -> one cycle later: NOP, pc_increment=1, all other enables 0, group=0.
- LUI {20'hCAD69, 5'b10101, 0110111} -> rd_addr=0x15, upper_imm=0xCAD69, rfile_we=1, pc_increment=1, group=3.
- AUIPC {20'h69CAD, 5'b01010, 0010111} -> rd_addr=0x0A, upper_imm=0x69CAD, group=4. Then JAL 0x0080_00EF -> rd=1, pc_we=1, pc_increment=0, group=5.
- SW x5,8(x2) = 0x0051_2423 -> rs1=2, rs2=5, low_imm=0x008, memory_we=1, rfile_we=0, op=2. LW x7,-4(x3) = 0xFFC1_A383 -> low_imm=0xFFC, memory_re=1.
- FENCE 0x0FF0_000F -> fence_sig=0xFF, fence_mode=0, group=10. Back-to-back instructions each decode correctly with 1-cycle latency.
